seg7_serial_decoder: RTL and testbench

- Inverse of the team's nibble-to-7-segment driver: recovers a hex nibble from a 7-segment pattern.
- The segment pattern arrives serially on the Tiny Tapeout 8-bit pin interface, one bit per enabled clock.
- Each completed 7-bit frame is matched against the 16-entry hex glyph table; the block presents the nibble, valid, error and overrun flags on io_out.
- Used as a loopback checker and readback path for segment-driver tiles.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_pattern_lookup.sv | 22 ++
 rtl/seg7_serial_decoder.sv | 144 ++++++++++++++
 tb/tb_seg7_serial_decoder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the serial 7-segment decoder: segment bit positions,
// the hex glyph table and the receive FSM states.
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;
   localparam int SEG_N = 7;

   typedef logic [SEG_N-1:0] seg_pat_t;

   // NOTE: GLYPH is a constant table folded into logic, not storage, so it has nothing to reset.
   localparam seg_pat_t GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      DECODE = 2'd2
   } state_e;

   // Common-anode segments are active-low; fold them back to active-high.
   function automatic seg_pat_t apply_polarity(input seg_pat_t raw, input logic invert);
      return raw ^ {SEG_N{invert}};
   endfunction

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse lookup: finds the hex digit whose glyph equals pat.
module seg7_pattern_lookup
   import seg7_pkg::*;
(
   input  logic [6:0] pat,
   output logic       hit,
   output logic [3:0] nib
);

   always_comb begin
      // NOTE: defaults first so every path assigns hit and nib and no latch is inferred.
      hit = 1'b0;
      nib = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (pat == GLYPH[i]) begin
            hit = 1'b1;
            nib = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg7_serial_decoder.sv
// Serial 7-segment pattern to hex nibble decoder on the Tiny Tapeout pin map;
// collects 7 bits LSB first, decodes one cycle later and flags misses and overruns.
module seg7_serial_decoder
   import seg7_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]    LAST_CNT = 3'd6;

   logic clk;
   logic rst_n;
   logic sdata;
   logic shift_en;
   logic ack;
   logic invert;
   logic unused_pins;

   assign clk         = io_in[0];
   assign rst_n       = io_in[1];
   assign sdata       = io_in[2];
   assign shift_en    = io_in[3];
   assign ack         = io_in[4];
   assign invert      = io_in[5];
   assign unused_pins = &{1'b0, io_in[7:6]};

   state_e            state;
   logic [2:0]        bit_cnt;
   seg_pat_t          shreg;
   logic [TO_W-1:0]   to_cnt;
   logic [3:0]        nibble;
   logic              valid;
   logic              err;
   logic              overrun;
   logic              busy;

   seg_pat_t          pat;
   logic              hit;
   logic [3:0]        nib;

   assign pat = apply_polarity(shreg, invert);

   seg7_pattern_lookup u_lookup (
      .pat (pat),
      .hit (hit),
      .nib (nib)
   );

   // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         to_cnt  <= '0;
         nibble  <= '0;
         valid   <= 1'b0;
         err     <= 1'b0;
         overrun <= 1'b0;
         busy    <= 1'b0;
      end else begin
         // Bits enter at G and walk down so segment A lands in bit 0 after 7 shifts.
         if (shift_en) begin
            shreg[SEG_G] <= sdata;
            shreg[SEG_F] <= shreg[SEG_G];
            shreg[SEG_E] <= shreg[SEG_F];
            shreg[SEG_D] <= shreg[SEG_E];
            shreg[SEG_C] <= shreg[SEG_D];
            shreg[SEG_B] <= shreg[SEG_C];
            shreg[SEG_A] <= shreg[SEG_B];
         end

         // A decode edge always wins over ack; ack alone retires valid and overrun.
         if (state == DECODE) begin
            nibble  <= hit ? nib : 4'h0;
            err     <= ~hit;
            valid   <= 1'b1;
            overrun <= valid & ~ack;
         end else if (ack) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
         end

         case (state)
            IDLE: begin
               to_cnt <= '0;
               if (shift_en) begin
                  bit_cnt <= 3'd1;
                  state   <= RECV;
                  busy    <= 1'b1;
               end
            end

            RECV: begin
               if (shift_en) begin
                  to_cnt  <= '0;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == LAST_CNT) begin
                     state <= DECODE;
                  end
               end else if (TO_EN) begin
                  if (to_cnt == TO_LAST) begin
                     to_cnt  <= '0;
                     bit_cnt <= '0;
                     state   <= IDLE;
                     busy    <= 1'b0;
                  end else begin
                     to_cnt <= to_cnt + TO_W'(1);
                  end
               end
            end

            DECODE: begin
               to_cnt <= '0;
               if (shift_en) begin
                  bit_cnt <= 3'd1;
                  state   <= RECV;
                  busy    <= 1'b1;
               end else begin
                  bit_cnt <= '0;
                  state   <= IDLE;
                  busy    <= 1'b0;
               end
            end

            default: begin
               to_cnt  <= '0;
               bit_cnt <= '0;
               state   <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   assign io_out = {busy, overrun, err, valid, nibble};

endmodule

// File: tb/tb_seg7_serial_decoder.sv
// Self-checking bench for seg7_serial_decoder: directed scenarios plus randomized
// frames compared against a transaction-level model of the decoder.
module tb_seg7_serial_decoder;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       sdata    = 1'b0;
   logic       shift_en = 1'b0;
   logic       ack      = 1'b0;
   logic       invert   = 1'b0;
   logic [1:0] junk     = 2'b00;
   logic [7:0] io_in;
   logic [7:0] io_out;

   int vectors     = 0;
   int miscompares = 0;

   // Model state, updated per transaction.
   logic [3:0] m_nib   = 4'h0;
   logic       m_valid = 1'b0;
   logic       m_err   = 1'b0;
   logic       m_ovr   = 1'b0;
   logic       m_busy  = 1'b0;

   localparam logic [6:0] REF_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   assign io_in = {junk, invert, ack, shift_en, sdata, rst_n, clk};

   seg7_serial_decoder #(
      .TIMEOUT_CYCLES (4),
      .TO_W           (8)
   ) dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   function automatic void ref_decode(input logic [6:0] p, output logic hit, output logic [3:0] nib);
      hit = 1'b0;
      nib = 4'h0;
      for (int d = 0; d < 16; d++) begin
         if (REF_GLYPH[d] == p) begin
            hit = 1'b1;
            nib = 4'(d);
         end
      end
   endfunction

   function automatic logic [7:0] exp_out();
      return {m_busy, m_ovr, m_err, m_valid, m_nib};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      junk = 2'($urandom);
   endtask

   // Shifts raw[first..last] LSB first, optional random idle gaps between bits.
   task automatic shift_bits(input logic [6:0] raw, input int first, input int last,
                             input int max_gap, input string tag);
      for (int i = first; i <= last; i++) begin
         shift_en = 1'b1;
         sdata    = raw[i];
         invert   = 1'($urandom);
         ack      = 1'b0;
         tick();
         m_busy = 1'b1;
         vectors++;
         if (io_out !== exp_out()) begin
            miscompares++;
            $display("FAIL %s bit%0d: io_out=%h expected %h", tag, i, io_out, exp_out());
         end
         if (i < 6 && max_gap > 0) begin
            repeat ($urandom_range(0, max_gap)) begin
               shift_en = 1'b0;
               tick();
               vectors++;
               if (io_out !== exp_out()) begin
                  miscompares++;
                  $display("FAIL %s gap after bit%0d: io_out=%h expected %h", tag, i, io_out, exp_out());
               end
            end
         end
      end
      shift_en = 1'b0;
   endtask

   // Drives the decode cycle and advances the model; callers do the comparison.
   task automatic decode_cycle(input logic [6:0] raw, input logic inv, input logic ack_v,
                               input logic chain, input logic next_bit);
      logic       hit;
      logic [3:0] nib;
      shift_en = chain;
      sdata    = next_bit;
      invert   = inv;
      ack      = ack_v;
      tick();
      ref_decode(raw ^ {7{inv}}, hit, nib);
      m_ovr   = m_valid & ~ack_v;
      m_valid = 1'b1;
      m_err   = ~hit;
      m_nib   = hit ? nib : 4'h0;
      m_busy  = chain;
      shift_en = 1'b0;
      ack      = 1'b0;
      invert   = 1'b0;
   endtask

   task automatic ack_pulse();
      shift_en = 1'b0;
      ack      = 1'b1;
      tick();
      ack     = 1'b0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (io_out !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_hold: io_out=%h expected 00", io_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      vectors++;
      if (io_out !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_release: io_out=%h expected 00", io_out);
      end
   endtask

   task automatic test_digit_two();
      shift_bits(7'h5B, 0, 6, 0, "digit2");
      decode_cycle(7'h5B, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (io_out !== 8'h12 || io_out !== exp_out()) begin
         miscompares++;
         $display("FAIL digit2_decode: io_out=%h expected 12", io_out);
      end
      ack_pulse();
      vectors++;
      if (io_out !== 8'h02) begin
         miscompares++;
         $display("FAIL digit2_ack: io_out=%h expected 02", io_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] nxt;
      for (int k = 0; k < 16; k++) begin
         nxt = (k < 15) ? REF_GLYPH[k+1] : 7'h00;
         shift_bits(REF_GLYPH[k], (k == 0) ? 0 : 1, 6, 0, "b2b");
         decode_cycle(REF_GLYPH[k], 1'b0, 1'b1, (k < 15), nxt[0]);
         vectors++;
         if (io_out[3:0] !== 4'(k) || io_out[6:4] !== 3'b001 || io_out !== exp_out()) begin
            miscompares++;
            $display("FAIL b2b_glyph%0d: io_out=%h expected nibble %0h valid only", k, io_out, k);
         end
      end
      ack_pulse();
   endtask

   task automatic test_miss_and_invert();
      shift_bits(7'h00, 0, 6, 1, "miss");
      decode_cycle(7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (io_out !== 8'h30) begin
         miscompares++;
         $display("FAIL miss_zero: io_out=%h expected 30", io_out);
      end
      ack_pulse();
      shift_bits(7'h79, 0, 6, 1, "inv");
      decode_cycle(7'h79, 1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (io_out !== 8'h11) begin
         miscompares++;
         $display("FAIL invert_one: io_out=%h expected 11", io_out);
      end
      ack_pulse();
      shift_bits(7'h79, 0, 6, 1, "noinv");
      decode_cycle(7'h79, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (io_out !== 8'h1E) begin
         miscompares++;
         $display("FAIL noinvert_e: io_out=%h expected 1e", io_out);
      end
      ack_pulse();
   endtask

   task automatic test_overrun();
      shift_bits(7'h4F, 0, 6, 0, "ovr1");
      decode_cycle(7'h4F, 1'b0, 1'b0, 1'b0, 1'b0);
      shift_bits(7'h07, 0, 6, 0, "ovr2");
      decode_cycle(7'h07, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (io_out !== 8'h57) begin
         miscompares++;
         $display("FAIL overrun_set: io_out=%h expected 57", io_out);
      end
      ack_pulse();
      vectors++;
      if (io_out !== 8'h07) begin
         miscompares++;
         $display("FAIL overrun_ack: io_out=%h expected 07", io_out);
      end
   endtask

   task automatic test_timeout();
      shift_bits(7'h2A, 0, 2, 0, "tmo_partial");
      for (int c = 1; c <= 4; c++) begin
         shift_en = 1'b0;
         tick();
         m_busy = (c < 4);
         vectors++;
         if (io_out[7] !== m_busy) begin
            miscompares++;
            $display("FAIL timeout_busy idle%0d: busy=%b expected %b", c, io_out[7], m_busy);
         end
      end
      shift_bits(7'h7F, 0, 6, 0, "tmo_eight");
      decode_cycle(7'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (io_out !== 8'h18) begin
         miscompares++;
         $display("FAIL timeout_eight: io_out=%h expected 18", io_out);
      end
      ack_pulse();
   endtask

   task automatic test_async_reset();
      shift_bits(7'h71, 0, 6, 0, "ar_pre");
      decode_cycle(7'h71, 1'b0, 1'b0, 1'b0, 1'b0);
      shift_bits(7'h6D, 0, 4, 0, "ar_part");
      #2;
      rst_n = 1'b0;
      #1;
      m_nib = 4'h0; m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
      vectors++;
      if (io_out !== 8'h00) begin
         miscompares++;
         $display("FAIL async_reset: io_out=%h expected 00", io_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      shift_bits(7'h6D, 0, 6, 0, "ar_five");
      decode_cycle(7'h6D, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (io_out !== 8'h15) begin
         miscompares++;
         $display("FAIL async_five: io_out=%h expected 15", io_out);
      end
      ack_pulse();
   endtask

   task automatic test_random();
      logic [6:0] cur_raw, nxt_raw;
      logic       cur_inv, nxt_inv, chain, ack_v, started;
      cur_inv = 1'($urandom);
      cur_raw = ($urandom_range(0, 1) == 1) ? (REF_GLYPH[$urandom_range(0, 15)] ^ {7{cur_inv}})
                                            : 7'($urandom);
      started = 1'b0;
      for (int f = 0; f < 150; f++) begin
         shift_bits(cur_raw, started ? 1 : 0, 6, 3, "rand");
         nxt_inv = 1'($urandom);
         nxt_raw = ($urandom_range(0, 1) == 1) ? (REF_GLYPH[$urandom_range(0, 15)] ^ {7{nxt_inv}})
                                               : 7'($urandom);
         chain = (f < 149) && ($urandom_range(0, 1) == 1);
         ack_v = 1'($urandom);
         decode_cycle(cur_raw, cur_inv, ack_v, chain, nxt_raw[0]);
         vectors++;
         if (io_out !== exp_out()) begin
            miscompares++;
            $display("FAIL rand_frame%0d raw=%h inv=%b: io_out=%h expected %h",
                     f, cur_raw, cur_inv, io_out, exp_out());
         end
         if ($urandom_range(0, 2) == 0) begin
            ack_pulse();
            vectors++;
            if (io_out !== exp_out()) begin
               miscompares++;
               $display("FAIL rand_ack%0d: io_out=%h expected %h", f, io_out, exp_out());
            end
         end
         started = chain;
         cur_raw = nxt_raw;
         cur_inv = nxt_inv;
      end
   endtask

   initial begin
      test_reset();
      test_digit_two();
      test_back_to_back();
      test_miss_and_invert();
      test_overrun();
      test_timeout();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
